// File: rtl/gselect_pkg.sv
// Shared widths, 2-bit counter encodings and saturating update for the gselect predictor.
package gselect_pkg;

    localparam int unsigned PC_W_DEF     = 8;
    localparam int unsigned PC_IDX_W_DEF = 4;
    localparam int unsigned GHR_W_DEF    = 4;
    localparam int unsigned CNT_W_DEF    = 32;

    // 2-bit direction counter; MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Saturating step toward the resolved outcome.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_e'(2'(cur + 2'd1));
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_e'(2'(cur - 2'd1));
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gselect_pht.sv
// Pattern history table: combinational read, clocked saturating update, bulk init to weakly not-taken.
module gselect_pht
    import gselect_pkg::*;
#(
    parameter int unsigned IDX_W = PC_IDX_W_DEF + GHR_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_e             rd_ctr_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    ctr_e pht_q [DEPTH];

    // Counter array: every entry back to WNT on reset, otherwise train one entry.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            pht_q[wr_idx] <= ctr_next(pht_q[wr_idx], wr_taken);
        end
    end

    assign rd_ctr_c = pht_q[rd_idx];

endmodule

// File: rtl/gselect.sv
// Gselect branch predictor: {pc low bits, global history} indexes a 2-bit counter table.
module gselect
    import gselect_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEF,
    parameter int unsigned PC_IDX_W = PC_IDX_W_DEF,
    parameter int unsigned GHR_W    = GHR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PC_W-1:0]  pc,
    input  logic             actual_taken,
    output logic             pred_taken,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = PC_IDX_W + GHR_W;

    logic [GHR_W-1:0] ghr_q;
    logic [IDX_W-1:0] idx_c;
    ctr_e             ctr_c;
    logic             mispredict_c;
    logic             unused_pc;

    // Upper pc bits do not take part in the index.
    assign unused_pc = ^pc;

    assign idx_c        = {pc[PC_IDX_W-1:0], ghr_q};
    assign pred_taken   = ctr_c[1];
    assign mispredict_c = pred_taken ^ actual_taken;

    // Read and train the same entry; the write lands at the edge, so a repeat hit next cycle sees it.
    gselect_pht #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (idx_c),
        .rd_ctr_c (ctr_c),
        .wr_en    (1'b1),
        .wr_idx   (idx_c),
        .wr_taken (actual_taken)
    );

    // Global history shift, newest outcome in the LSB.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= GHR_W'({ghr_q, actual_taken});
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            mispredict_count <= '0;
        end else if (mispredict_c && (mispredict_count != {CNT_W{1'b1}})) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gselect.sv
// Scoreboard bench for gselect: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_gselect;

    logic        clk;
    logic        reset_n;
    logic [7:0]  pc;
    logic        actual_taken;
    logic        pred_taken;
    logic [31:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    logic obs_valid;
    logic        exp_pred_q [$];
    logic [31:0] exp_cnt_q  [$];
    int          tag_q      [$];

    // Alternating scenario on pc 0x07: expected prediction and count before each branch.
    logic d_pred [12] = '{0,0,0,0,0,0,1,0,1,0,1,0};
    int   d_cnt  [12] = '{0,1,1,2,2,3,3,3,3,3,3,3};

    // Saturation/decay scenario: pc 0x01 hits {1,1111}; pc 0x02 fillers restore history to 1111.
    logic [7:0] e_pc [28] = '{8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,
                              8'h02,8'h02,8'h02,8'h02,8'h01,
                              8'h02,8'h02,8'h02,8'h02,
                              8'h01,8'h01,8'h01,8'h01,8'h01,
                              8'h02,8'h02,8'h02,8'h02,8'h01};
    logic e_t    [28] = '{1,1,1,1,1,1,1,1,0, 1,1,1,1,0, 1,1,1,1, 1,1,1,1,0, 1,1,1,1,0};
    logic e_p    [28] = '{0,0,0,0,0,1,1,1,1, 0,0,0,0,1, 1,1,1,1, 0,1,1,1,1, 1,1,1,1,1};
    int   e_c    [28] = '{0,1,2,3,4,5,5,5,5, 6,7,8,9,10, 11,11,11,11, 11,12,12,12,12, 13,13,13,13,13};

    gselect dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc               (pc),
        .actual_taken     (actual_taken),
        .pred_taken       (pred_taken),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one branch and queue what the DUT should show for it.
    task automatic do_branch(input logic [7:0] p, input logic t, input logic ep, input int ec, input int tag);
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        pc           = p;
        actual_taken = t;
        exp_pred_q.push_back(ep);
        exp_cnt_q.push_back(32'(ec));
        tag_q.push_back(tag);
        obs_valid    = 1'b1;
    endtask

    // Observe current state for pc p, then reset on the following edge.
    task automatic check_then_reset(input logic [7:0] p, input logic ep, input int ec, input int tag);
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        pc           = p;
        actual_taken = 1'b0;
        exp_pred_q.push_back(ep);
        exp_cnt_q.push_back(32'(ec));
        tag_q.push_back(tag);
        obs_valid    = 1'b1;
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        obs_valid = 1'b0;
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: mid-cycle, compare the combinational prediction and the pre-update count.
    always @(negedge clk) begin
        if (obs_valid) begin
            if (exp_pred_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: observation with empty scoreboard");
            end else begin
                logic        ep;
                logic [31:0] ec;
                int          tg;
                ep = exp_pred_q.pop_front();
                ec = exp_cnt_q.pop_front();
                tg = tag_q.pop_front();
                checks++;
                if (pred_taken !== ep) begin
                    failures++;
                    $display("FAIL pred_taken tag=%0d got=%b exp=%b", tg, pred_taken, ep);
                end
                checks++;
                if (mispredict_count !== ec) begin
                    failures++;
                    $display("FAIL mispredict_count tag=%0d got=%0d exp=%0d", tg, mispredict_count, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b1;
        pc           = '0;
        actual_taken = 1'b0;
        obs_valid    = 1'b0;

        // Reset then idle reads.
        apply_reset(2);
        do_branch(8'h00, 1'b0, 1'b0, 0, 100);
        do_branch(8'h5A, 1'b0, 1'b0, 0, 101);
        do_branch(8'hFF, 1'b0, 1'b0, 0, 102);
        check_then_reset(8'h00, 1'b0, 0, 103);

        // Always not-taken on pc 0x10.
        for (int i = 0; i < 20; i++) begin
            do_branch(8'h10, 1'b0, 1'b0, 0, 200 + i);
        end
        check_then_reset(8'h10, 1'b0, 0, 299);

        // Always taken on pc 0x23; first five branches walk fresh entries.
        for (int i = 0; i < 10; i++) begin
            do_branch(8'h23, 1'b1, (i >= 5) ? 1'b1 : 1'b0, (i < 5) ? i : 5, 300 + i);
        end
        check_then_reset(8'h23, 1'b1, 5, 399);

        // Same scenario after a mid-stream reset must repeat exactly.
        for (int i = 0; i < 10; i++) begin
            do_branch(8'h23, 1'b1, (i >= 5) ? 1'b1 : 1'b0, (i < 5) ? i : 5, 400 + i);
        end
        check_then_reset(8'h23, 1'b1, 5, 499);

        // Alternating T,N on pc 0x07.
        for (int i = 0; i < 12; i++) begin
            do_branch(8'h07, (i % 2 == 0) ? 1'b1 : 1'b0, d_pred[i], d_cnt[i], 500 + i);
        end
        check_then_reset(8'h07, 1'b1, 3, 599);

        // Saturation and decay of entry {1,1111}.
        for (int i = 0; i < 28; i++) begin
            do_branch(e_pc[i], e_t[i], e_p[i], e_c[i], 600 + i);
        end
        check_then_reset(8'h01, 1'b0, 14, 699);

        @(posedge clk);
        #1;
        obs_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;

        checks++;
        if (exp_pred_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got=%0d leftover exp=0", exp_pred_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gselect.md
Name: gselect

Overview:
- Global-history gselect branch direction predictor.
- Forms a pattern-history-table (PHT) index by concatenating low PC bits with a global history register (GHR).
- Predicts combinationally from a table of 2-bit saturating counters.
- Trains every clock on the resolved outcome and keeps a running mispredict count for performance evaluation in the front-end/branch-unit model.

Parameters:
- PC_W, 8, width of pc input
- PC_IDX_W, 4, low pc bits used in index (≤ PC_W)
- GHR_W, 4, global history length in bits
- CNT_W, 32, width of mispredict_count

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous reset, active-high (asserted = 1); name kept per codebase
- pc  input  PC_W  branch address for current cycle; one branch resolved per cycle
- actual_taken  input  1  resolved outcome of branch at pc (1 = taken)
- pred_taken  output  1  prediction for pc, combinational
- mispredict_count  output  CNT_W  number of mispredicted branches since reset

Behaviour:
- PHT: 2^(PC_IDX_W+GHR_W) entries (256 by default), each a 2-bit counter.
  - Encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- Index: idx = {pc[PC_IDX_W-1:0], ghr[GHR_W-1:0]}, with pc bits in the MSBs.
- pred_taken = PHT[idx][1]. Purely combinational from current pc and ghr, so zero latency.
- Reset (reset_n=1 at rising edge):
  - every PHT entry = 01 (weakly not-taken);
  - ghr = 0;
  - mispredict_count = 0.
  - pred_taken then reads 0 for any pc.
  - Reset mid-stream discards all training and the count; no update occurs in a reset cycle.
- Every non-reset rising edge treats pc/actual_taken as one valid branch. There is no valid qualifier.
  - Counter at idx (the same idx that produced pred_taken this cycle): +1 if actual_taken, saturating at 11; −1 otherwise, saturating at 00.
  - ghr <= {ghr[GHR_W-2:0], actual_taken}, newest outcome in LSB.
  - If pred_taken != actual_taken, mispredict_count increments by 1, saturating at all-ones (no wrap).
- All three updates in a cycle use pre-edge values. Counter write and history shift are simultaneous, and the next cycle's index uses the new ghr.
- Back-to-back branches to the same idx: the second one sees the first one's update (write-then-read across the edge; no bypass needed within a cycle).
- PHT may be flops or a memory with a combinational read port. It must support reset-to-01 of all entries in a single reset cycle.
- No X on outputs after the first reset edge.

Decomposition:
- Package gselect_pkg holds:
  - default widths;
  - the 2-bit counter encodings (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11) and the reset value WNT;
  - a function for saturating counter next-state.
- One natural sub-module, gselect_pht. It holds the counter array with:
  - a combinational read port (idx → counter);
  - a synchronous write/update port (idx, taken);
  - synchronous init-to-WNT on reset.
- The top level holds ghr, the index concatenation, the mispredict comparator and the counter.

Test Plan:
- Reset then idle check: reset_n=1 for 2 cycles, then 0. pred_taken=0 for pc=00, 5A and FF; mispredict_count=0.
- Always-not-taken: pc=0x10 with actual_taken=0 for 20 cycles. ghr stays 0 and pred_taken stays 0 → mispredict_count=0.
- Always-taken, single pc=0x23, actual_taken=1 for 10 cycles. ghr steps 0000→0001→0011→0111→1111; each new index starts at WNT. Result: mispredicts on the first 5 branches, pred_taken=1 from the 6th branch on, final mispredict_count=5.
- Alternating T,N,T,N… on pc=0x07 for 12 branches. Mispredicts only on branches 1, 3 and 5, so final count=3. pred_taken matches actual_taken from branch 6 onward.
- Saturation and decay, pc=0x01 with constant history:
  - Preload: a run of Ts so idx {1,1111} reaches 11.
  - Apply N, N with the history re-driven to 1111 (i.e. T,N,T,T… pattern arranged so the same idx is hit). Verify counter 11→10 still predicts taken, then 10→01 predicts not-taken.
  - Also confirm the counter never exceeds 11 after further Ts.
- Reset mid-stream: after the always-taken scenario (count=5), assert reset_n=1 for one edge. mispredict_count=0 and pred_taken=0 for pc=0x23; repeating the always-taken scenario again yields a count of 5.
